// File: rtl/pwm_dimmer_pkg.sv
// rtl/pwm_dimmer_pkg.sv - shared types and the duty gamma helper for pwm_dimmer
package pwm_dimmer_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam int unsigned GAMMA_MAX_W = 32;

   // Squares the duty and renormalises; the +2^w-1 bias keeps 2^w-1 mapped onto itself.
   function automatic logic [GAMMA_MAX_W-1:0] gamma_corr(input logic [GAMMA_MAX_W-1:0] duty,
                                                         input int unsigned w);
      logic [2*GAMMA_MAX_W-1:0] sq;
      logic [2*GAMMA_MAX_W-1:0] shifted;
      sq      = {{GAMMA_MAX_W{1'b0}}, duty} * {{GAMMA_MAX_W{1'b0}}, duty};
      sq      = sq + ((64'd1 << w) - 64'd1);
      shifted = sq >> w;
      return shifted[GAMMA_MAX_W-1:0];
   endfunction

endpackage

// File: rtl/pwm_dimmer_tick_gen.sv
// rtl/pwm_dimmer_tick_gen.sv - prescaler producing one PWM tick every PRESCALE clk cycles
module tick_gen #(
   parameter int PRESCALE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PW-1:0] pre_cnt_q;
   logic [PW-1:0] pre_cnt_d;

   // With PRESCALE=1 the count stays at zero and tick is high whenever not cleared.
   assign tick = !clr && (pre_cnt_q == PW'(PRESCALE - 1));

   always_comb begin
      pre_cnt_d = pre_cnt_q + PW'(1);
      if (clr || tick) begin
         pre_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_cnt_q <= '0;
      end else begin
         pre_cnt_q <= pre_cnt_d;
      end
   end

endmodule

// File: rtl/pwm_dimmer.sv
// rtl/pwm_dimmer.sv - fixed-period PWM LED driver with shadowed duty register
// Optional perceptual duty correction at latch time: define PWM_DIMMER_GAMMA_EN.
module pwm_dimmer
   import pwm_dimmer_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] duty,
   output logic             pwm_out,
   output logic             period_start,
   output logic [WIDTH-1:0] duty_active
);

   localparam int PHASE_MAX = (2 ** WIDTH) - 2;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] phase_q, phase_d;
   logic [WIDTH-1:0] duty_active_q, duty_active_d;
   logic             pwm_q, pwm_d;
   logic             period_start_q, period_start_d;
   logic             tick;
   logic             clr;
   logic [WIDTH-1:0] duty_lat;

`ifdef PWM_DIMMER_GAMMA_EN
   logic [GAMMA_MAX_W-1:0] duty_ext;
   logic [GAMMA_MAX_W-1:0] duty_gamma;

   always_comb begin
      duty_ext              = '0;
      duty_ext[WIDTH-1:0]   = duty;
      duty_gamma            = gamma_corr(duty_ext, WIDTH);
      duty_lat              = duty_gamma[WIDTH-1:0];
   end
`else
   assign duty_lat = duty;
`endif

   // Prescaler only runs while in RUN with en held; any exit restarts it from zero.
   assign clr = (state_q != RUN) || !en;

   tick_gen #(
      .PRESCALE(PRESCALE)
   ) u_tick_gen (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .tick(tick)
   );

   always_comb begin
      state_d        = state_q;
      phase_d        = phase_q;
      duty_active_d  = duty_active_q;
      pwm_d          = pwm_q;
      period_start_d = 1'b0;
      case (state_q)
         IDLE: begin
            phase_d = '0;
            pwm_d   = 1'b0;
            if (en) begin
               state_d        = RUN;
               duty_active_d  = duty_lat;
               period_start_d = 1'b1;
            end
         end
         RUN: begin
            if (!en) begin
               state_d = IDLE;
               phase_d = '0;
               pwm_d   = 1'b0;
            end else begin
               pwm_d = (phase_q < duty_active_q);
               if (tick) begin
                  if (phase_q == WIDTH'(PHASE_MAX)) begin
                     phase_d        = '0;
                     duty_active_d  = duty_lat;
                     period_start_d = 1'b1;
                  end else begin
                     phase_d = phase_q + WIDTH'(1);
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         phase_q        <= '0;
         duty_active_q  <= '0;
         pwm_q          <= 1'b0;
         period_start_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         phase_q        <= phase_d;
         duty_active_q  <= duty_active_d;
         pwm_q          <= pwm_d;
         period_start_q <= period_start_d;
      end
   end

   assign pwm_out      = pwm_q;
   assign period_start = period_start_q;
   assign duty_active  = duty_active_q;

endmodule
